// File: rtl/memory_cycle.sv
// memory_cycle: memory pipeline stage of the 18-bit processor.
//   Takes the E/M register outputs and runs loads and stores against an
//   external data memory over a req/ready handshake. Holds the M/W register
//   and drives the write-back signals, including the forwarded ResultW.
//   While an access is outstanding it asserts StallM to freeze upstream.
//
// Optional build macro: MEM_TIMEOUT_EN. When defined, an access that stays
//   in WAIT for TIMEOUT cycles without mem_ready is aborted and the sticky
//   mem_err flag is set. When undefined, WAIT lasts until mem_ready and
//   mem_err is tied to 0.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   RegWriteM, MemWriteM,
//   ResultSrcM, RD_M,
//   PCPlus4M, WriteDataM,
//   ALU_ResultM, RGB_M       E/M register outputs (ALU_ResultM is the address)
//   mem_req, mem_we,
//   mem_addr, mem_wdata      request side of the memory handshake
//   mem_rdata, mem_ready     response side (rdata valid when ready)
//   StallM                   freezes PC, F/D, D/E and E/M registers
//   RegWriteW, ResultSrcW,
//   RD_W, ReadDataW,
//   ALU_ResultW, PCPlus4W,
//   RGB_W                    M/W register outputs
//   ResultW                  ResultSrcW ? ReadDataW : ALU_ResultW
//   mem_err                  sticky timeout flag
module memory_cycle #(
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RD_M,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALU_ResultM,
  input  logic [1:0]        RGB_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RD_W,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic [1:0]        RGB_W,
  output logic [DATA_W-1:0] ResultW,
  output logic              mem_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic              reg_write;
    logic              result_src;
    logic [4:0]        rd;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc_plus4;
    logic [1:0]        rgb;
  } mw_t;

  state_t state_q, state_d;
  mw_t    mw_q, mw_d;
  logic   access, req, stall, done, abort;

  assign access = MemWriteM | ResultSrcM;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // wait_cnt holds the number of WAIT cycles already spent, so the abort
  // fires in the TIMEOUT-th WAIT cycle unless ready arrives in it.
  assign abort = (state_q == S_WAIT) & ~mem_ready & (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == S_WAIT) && stall) wait_cnt <= wait_cnt + 1'b1;
      else                              wait_cnt <= '0;
      if (abort) err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Reset overrides the request combinationally so an in-flight access is
  // dropped; in WAIT the request is held even though access is stable anyway.
  assign req   = rst & (access | (state_q == S_WAIT)) & ~abort;
  assign stall = req & ~mem_ready;
  assign done  = req & mem_ready;

  assign mem_req   = req;
  assign mem_we    = req & MemWriteM;
  assign mem_addr  = ALU_ResultM;
  assign mem_wdata = WriteDataM;
  assign StallM    = stall;

  always_comb begin
    state_d = stall ? S_WAIT : S_IDLE;

    mw_d.reg_write  = RegWriteM;
    mw_d.result_src = ResultSrcM;
    mw_d.rd         = RD_M;
    // Read data only lands for a pure load; a combined load+store is a store.
    mw_d.read_data  = (done && ResultSrcM && !MemWriteM) ? mem_rdata : '0;
    mw_d.alu_result = ALU_ResultM;
    mw_d.pc_plus4   = PCPlus4M;
    mw_d.rgb        = RGB_M;

    if (stall) begin
      mw_d = '0;
    end else if (abort) begin
      mw_d.reg_write = 1'b0;
      mw_d.read_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      mw_q    <= mw_d;
    end
  end

  assign RegWriteW   = mw_q.reg_write;
  assign ResultSrcW  = mw_q.result_src;
  assign RD_W        = mw_q.rd;
  assign ReadDataW   = mw_q.read_data;
  assign ALU_ResultW = mw_q.alu_result;
  assign PCPlus4W    = mw_q.pc_plus4;
  assign RGB_W       = mw_q.rgb;
  assign ResultW     = mw_q.result_src ? mw_q.read_data : mw_q.alu_result;

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0;
  logic [4:0]   RD_M = '0;
  logic [W-1:0] PCPlus4M = '0, WriteDataM = '0, ALU_ResultM = '0;
  logic [1:0]   RGB_M = '0;
  logic         mem_req, mem_we, StallM, mem_err;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic         RegWriteW, ResultSrcW;
  logic [4:0]   RD_W;
  logic [W-1:0] ReadDataW, ALU_ResultW, PCPlus4W, ResultW;
  logic [1:0]   RGB_W;

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;

  memory_cycle #(.DATA_W(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM), .RGB_M(RGB_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .ReadDataW(ReadDataW), .ALU_ResultW(ALU_ResultW), .PCPlus4W(PCPlus4W),
    .RGB_W(RGB_W), .ResultW(ResultW), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic rw, input logic rs,
                         input logic [4:0] rd, input logic [W-1:0] rdata,
                         input logic [W-1:0] alu, input logic [W-1:0] pc,
                         input logic [1:0] rgb);
    chk({tag, ".RegWriteW"},   RegWriteW,   rw);
    chk({tag, ".ResultSrcW"},  ResultSrcW,  rs);
    chk({tag, ".RD_W"},        RD_W,        rd);
    chk({tag, ".ReadDataW"},   ReadDataW,   rdata);
    chk({tag, ".ALU_ResultW"}, ALU_ResultW, alu);
    chk({tag, ".PCPlus4W"},    PCPlus4W,    pc);
    chk({tag, ".RGB_W"},       RGB_W,       rgb);
    chk({tag, ".ResultW"},     ResultW,     rs ? rdata : alu);
  endtask

  task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [W-1:0] pc, input logic [W-1:0] wd,
                       input logic [W-1:0] alu, input logic [1:0] rgb);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu; RGB_M = rgb;
  endtask

  // Presents one instruction (called #1 after a rising edge) whose memory
  // answers after k wait cycles, and checks the handshake each cycle plus the
  // k bubbles and the final write-back contents.
  task automatic run_instr(input string tag, input logic rw, input logic mw, input logic rs,
                           input logic [4:0] rd, input logic [W-1:0] pc, input logic [W-1:0] wd,
                           input logic [W-1:0] alu, input logic [1:0] rgb, input int k,
                           input logic [W-1:0] rdata);
    logic         acc;
    logic [W-1:0] exp_rd;
    acc    = mw | rs;
    exp_rd = (rs && !mw) ? rdata : '0;
    drive(rw, mw, rs, rd, pc, wd, alu, rgb);
    for (int i = 0; i <= k; i++) begin
      mem_ready = acc ? (i == k) : 1'($urandom);
      mem_rdata = (i == k) ? rdata : W'($urandom);
      @(negedge clk);
      chk({tag, ".mem_req"}, mem_req, acc);
      chk({tag, ".StallM"},  StallM,  acc && (i < k));
      if (acc) begin
        chk({tag, ".mem_we"},    mem_we,    mw);
        chk({tag, ".mem_addr"},  mem_addr,  alu);
        chk({tag, ".mem_wdata"}, mem_wdata, wd);
      end
      @(posedge clk); #1;
      if (i < k) check_w({tag, ".bubble"}, 0, 0, '0, '0, '0, '0, '0);
      else       check_w(tag, rw, rs, rd, exp_rd, alu, pc, rgb);
    end
    mem_ready = 1'b0;
    chk({tag, ".mem_err"}, mem_err, exp_err);
  endtask

  initial begin
    // Reset with an access presented: request must stay low while rst=0.
    rst = 1'b0;
    drive(1, 0, 1, 5'd3, 18'h1, 18'h2, 18'h3, 2'd1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_we",  mem_we,  0);
    chk("rst.StallM",  StallM,  0);
    @(posedge clk); #1;
    check_w("rst", 0, 0, '0, '0, '0, '0, '0);
    chk("rst.mem_err", mem_err, 0);
    mem_ready = 1'b0;
    drive(0, 0, 0, '0, '0, '0, '0, '0);
    rst = 1'b1;

    run_instr("zw_load", 1, 0, 1, 5'd5,  18'h4,     18'h0,    18'h00010, 2'd0, 0, 18'h2ABCD);
    run_instr("st_wait", 0, 1, 0, 5'd7,  18'h8,     18'h1234, 18'h00040, 2'd1, 3, 18'h0);
    run_instr("alu_op",  1, 0, 0, 5'd31, 18'hC,     18'h55,   18'h3FFFF, 2'd2, 0, 18'h0);
    run_instr("ld_st",   1, 1, 1, 5'd9,  18'h10,    18'h777,  18'h00123, 2'd3, 2, 18'h3AAAA);

    // Reset in the middle of WAIT abandons the access.
    drive(1, 0, 1, 5'd12, 18'h20, 18'h0, 18'h00050, 2'd1);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw.StallM_pre", StallM, 1);
    rst = 1'b0;
    #1;
    chk("rstw.mem_req", mem_req, 0);
    chk("rstw.StallM",  StallM,  0);
    @(posedge clk); #1;
    check_w("rstw", 0, 0, '0, '0, '0, '0, '0);
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0, '0, '0);
    #1;
    chk("rstw.idle_req", mem_req, 0);
    run_instr("post_rst", 1, 0, 1, 5'd13, 18'h24, 18'h0, 18'h00060, 2'd2, 1, 18'h1F00F);

`ifdef MEM_TIMEOUT_EN
    begin
      int stall_cycles = 0;
      int guard = 0;
      drive(1, 0, 1, 5'd20, 18'h30, 18'h0, 18'h00070, 2'd3);
      mem_ready = 1'b0;
      @(negedge clk);
      while (mem_req === 1'b1 && guard < 40) begin
        if (StallM === 1'b1) stall_cycles++;
        guard++;
        @(negedge clk);
      end
      chk("tmo.bounded",      guard < 40, 1);
      chk("tmo.stall_cycles", stall_cycles, 15);
      chk("tmo.abort_stall",  StallM, 0);
      @(posedge clk); #1;
      exp_err = 1'b1;
      chk("tmo.mem_err",   mem_err,   1);
      chk("tmo.RegWriteW", RegWriteW, 0);
      chk("tmo.ReadDataW", ReadDataW, 0);
      chk("tmo.RD_W",      RD_W,      5'd20);
      run_instr("tmo_next", 1, 0, 1, 5'd21, 18'h34, 18'h0, 18'h00074, 2'd0, 1, 18'h0BEEF);
    end
`endif

    // Randomized back-to-back traffic.
    for (int n = 0; n < 40; n++) begin
      logic mw, rs;
      int   k;
      mw = 1'($urandom);
      rs = 1'($urandom);
      k  = (mw | rs) ? int'($urandom_range(0, 4)) : 0;
      run_instr("rand", 1'($urandom), mw, rs, 5'($urandom), W'($urandom), W'($urandom),
                W'($urandom), 2'($urandom), k, W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory pipeline stage of the 18-bit processor, directly downstream of `execute_cycle`. It consumes the E/M register outputs, performs loads and stores against an external data memory through a req/ready handshake, and holds the M/W pipeline register. It produces the write-back signals, including the forwarded `ResultW`. While a memory access is outstanding it stalls every upstream stage.

## Interface
Parameters:
- `DATA_W`, 18, datapath and memory word width.
- `TIMEOUT`, 15, maximum wait cycles before abort; used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `RegWriteM`, `MemWriteM`, `ResultSrcM` in 1 each: control bits from execute (ResultSrcM=1 means load).
- `RD_M` in 5: destination register.
- `PCPlus4M`, `WriteDataM`, `ALU_ResultM` in DATA_W each; `ALU_ResultM` is the memory address.
- `RGB_M` in 2: pixel-channel tag, passed through.
- `mem_req` out 1: access request.
- `mem_we` out 1: 1 = write.
- `mem_addr`, `mem_wdata` out DATA_W each.
- `mem_rdata` in DATA_W: read data, valid when `mem_ready`=1.
- `mem_ready` in 1: access completes this cycle.
- `StallM` out 1: freezes the PC, F/D, D/E and E/M registers.
- `RegWriteW`, `ResultSrcW` out 1 each.
- `RD_W` out 5.
- `ReadDataW`, `ALU_ResultW`, `PCPlus4W` out DATA_W each.
- `RGB_W` out 2.
- `ResultW` out DATA_W: `ResultSrcW` ? `ReadDataW` : `ALU_ResultW`.
- `mem_err` out 1: sticky timeout flag.

## Operation
- `access = MemWriteM | ResultSrcM`.
  - When both bits are set, the write takes priority: the store executes and `ReadDataW` is captured as 0.
- The FSM has states IDLE and WAIT.
- IDLE:
  - If `access` is 0, `mem_req` is 0 and the M/W register loads the M inputs (`ReadDataW` loads 0).
  - If `access` is 1, `mem_req` is 1 in the same cycle, with `mem_we=MemWriteM`, `mem_addr=ALU_ResultM` and `mem_wdata=WriteDataM`.
    - If `mem_ready`=1 in that cycle, the access completes: the M/W register captures the inputs plus `mem_rdata` (for a load), and the FSM stays in IDLE.
    - Otherwise the FSM goes to WAIT.
- WAIT:
  - `mem_req` stays 1 and `mem_we`, `mem_addr` and `mem_wdata` stay stable; the M inputs are stable because upstream is stalled.
  - `StallM`=1.
  - The M/W register loads a bubble each cycle: RegWriteW=0, ResultSrcW=0, RD_W=0, data fields 0, RGB_W=0.
  - On `mem_ready`=1: the access completes as in IDLE, `StallM`=0 in that cycle, and the FSM returns to IDLE.
- `StallM = mem_req & ~mem_ready` (combinational). It therefore covers both the IDLE first cycle and WAIT.
- `mem_ready` while `mem_req`=0 is ignored.
- Reset (`rst`=0 at a rising edge):
  - State goes to IDLE; all M/W outputs go to 0; `mem_err` goes to 0; the wait counter goes to 0.
  - While `rst`=0, `mem_req`, `mem_we` and `StallM` are forced to 0 combinationally. This holds even during WAIT, so an in-flight access is abandoned.

## Timing
- Zero-wait access: inputs are presented in cycle N; the W outputs are valid after edge N+1.
- An access with k wait cycles (`mem_ready` first high k cycles after the request starts):
  - W outputs are valid after edge N+k+1.
  - `StallM` is high for cycles N..N+k-1.
  - k bubbles enter write-back.
- `ResultW` is combinational from the M/W register, so it is valid in the same cycle as the other W outputs.
- Back-to-back accesses are allowed: a new request can start in the cycle immediately after a completion.
- Reset values: RegWriteW=0, ResultSrcW=0, RD_W=0, ReadDataW=0, ALU_ResultW=0, PCPlus4W=0, RGB_W=0, ResultW=0, mem_err=0, mem_req=0, mem_we=0, StallM=0.
  - `mem_addr` and `mem_wdata` follow the inputs and are don't-care while `mem_req`=0.

## Configuration
- Macro: `MEM_TIMEOUT_EN`.
- When defined:
  - A wait counter increments each cycle in WAIT.
  - If it reaches `TIMEOUT` without `mem_ready`, the access aborts in that cycle:
    - `mem_req`=0 and `StallM`=0.
    - The M/W register captures the instruction with RegWriteW=0 and ReadDataW=0.
    - `mem_err` is set.
    - The FSM goes to IDLE.
  - `mem_err` stays set until reset.
  - The counter clears on every completion or abort.
- When not defined:
  - WAIT lasts indefinitely until `mem_ready`.
  - No counter is present.
  - `mem_err` is tied to 0.

## Test plan
- Zero-wait load: ALU_ResultM=0x00010, ResultSrcM=1, RegWriteM=1, RD_M=5, `mem_ready`=1 with `mem_rdata`=0x2ABCD → next cycle RegWriteW=1, RD_W=5, ResultW=0x2ABCD; StallM never high.
- Store with 3 wait cycles: WriteDataM=0x1234, address 0x0040 → mem_req/mem_we high for 4 cycles with address and data stable; StallM high for 3 cycles; 3 bubbles with RegWriteW=0; then MemWrite completes and RegWriteW=0.
- ALU op with no access: ALU_ResultM=0x3FFFF, RegWriteM=1, RD_M=31, RGB_M=2 → next cycle ResultW=0x3FFFF, RD_W=31, RGB_W=2, mem_req=0.
- Reset mid-WAIT: load stalled 2 cycles, then `rst`=0 for 1 edge → mem_req=0 and StallM=0 during reset; all W outputs 0 after the edge; FSM in IDLE.
- Load and store set together: MemWriteM=1 and ResultSrcM=1 → mem_we=1; ReadDataW=0 after completion.
- With `MEM_TIMEOUT_EN` and TIMEOUT=15: load with `mem_ready` held at 0 → abort at wait count 15; mem_err=1 and stays set; RegWriteW=0; the next access proceeds normally.
